// File: rtl/time_of_day.sv
// time_of_day: HH:MM:SS counter driven by a prescaled 1 Hz tick.
// It has an interactive six-button editor that works on a shadow copy of the time.
// The one-cycle carry_out pulse at midnight feeds the carry_in of the downstream date block.
module time_of_day #(
  parameter int CLK_HZ = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        enter,
  input  logic        esc,
  input  logic        mode,
  output logic        carry_out,
  output logic [47:0] out,
  output logic        norm,
  output logic [6:0]  hour,
  output logic [6:0]  minute,
  output logic [6:0]  second
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  typedef enum logic { RUN, EDIT } state_t;
  typedef enum logic [1:0] { SEL_HOUR, SEL_MIN, SEL_SEC } sel_t;

  state_t        state_q, state_d;
  sel_t          sel_q, sel_d;
  logic [CW-1:0] count_q, count_d;
  logic [5:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [5:0]    sh_hour_q, sh_hour_d, sh_min_q, sh_min_d, sh_sec_q, sh_sec_d;
  logic          carry_q, carry_d;
  logic          norm_q, norm_d;
  logic [47:0]   out_q, out_d;
  logic          tick;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    return (v >= top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] top);
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  function automatic logic [15:0] to_ascii(input logic [5:0] v);
    logic [5:0] t;
    logic [5:0] u;
    t = v / 6'd10;
    u = v % 6'd10;
    return {8'h30 + {2'b00, t}, 8'h30 + {2'b00, u}};
  endfunction

  // Next-state logic.
  // Covers the prescaler, the live time, the RUN/EDIT editor and the registered display.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    sh_hour_d = sh_hour_q;
    sh_min_d  = sh_min_q;
    sh_sec_d  = sh_sec_q;
    carry_d   = 1'b0;

    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + 1'b1;

    if (tick) begin
      sec_d = wrap_inc(sec_q, 6'd59);
      if (sec_q == 6'd59) begin
        min_d = wrap_inc(min_q, 6'd59);
        if (min_q == 6'd59) begin
          hour_d = wrap_inc(hour_q, 6'd23);
        end
      end
      carry_d = (sec_q == 6'd59) && (min_q == 6'd59) && (hour_q == 6'd23);
    end

    case (state_q)
      RUN: begin
        if (enter && mode) begin
          state_d   = EDIT;
          sel_d     = SEL_HOUR;
          sh_hour_d = hour_q;
          sh_min_d  = min_q;
          sh_sec_d  = sec_q;
        end
      end
      EDIT: begin
        if (esc) begin
          state_d = RUN;
        end else if (enter) begin
          // A commit overrides any tick that lands in the same cycle.
          state_d = RUN;
          hour_d  = sh_hour_q;
          min_d   = sh_min_q;
          sec_d   = sh_sec_q;
          count_d = '0;
          carry_d = 1'b0;
        end else if (up) begin
          case (sel_q)
            SEL_HOUR: sh_hour_d = wrap_inc(sh_hour_q, 6'd23);
            SEL_MIN:  sh_min_d  = wrap_inc(sh_min_q, 6'd59);
            default:  sh_sec_d  = wrap_inc(sh_sec_q, 6'd59);
          endcase
        end else if (down) begin
          case (sel_q)
            SEL_HOUR: sh_hour_d = wrap_dec(sh_hour_q, 6'd23);
            SEL_MIN:  sh_min_d  = wrap_dec(sh_min_q, 6'd59);
            default:  sh_sec_d  = wrap_dec(sh_sec_q, 6'd59);
          endcase
        end else if (left) begin
          case (sel_q)
            SEL_SEC: sel_d = SEL_MIN;
            default: sel_d = SEL_HOUR;
          endcase
        end else if (right) begin
          case (sel_q)
            SEL_HOUR: sel_d = SEL_MIN;
            default:  sel_d = SEL_SEC;
          endcase
        end
      end
      default: state_d = RUN;
    endcase

    norm_d = (state_d == RUN);

    if (state_q == RUN) begin
      out_d = {to_ascii(hour_q), to_ascii(min_q), to_ascii(sec_q)};
    end else begin
      out_d = {to_ascii(sh_hour_q), to_ascii(sh_min_q), to_ascii(sh_sec_q)};
    end
  end

  // State registers with asynchronous reset back to RUN at 00:00:00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      sel_q     <= SEL_HOUR;
      count_q   <= '0;
      hour_q    <= 6'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      sh_hour_q <= 6'd0;
      sh_min_q  <= 6'd0;
      sh_sec_q  <= 6'd0;
      carry_q   <= 1'b0;
      norm_q    <= 1'b1;
      out_q     <= 48'h303030303030;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      count_q   <= count_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      sh_hour_q <= sh_hour_d;
      sh_min_q  <= sh_min_d;
      sh_sec_q  <= sh_sec_d;
      carry_q   <= carry_d;
      norm_q    <= norm_d;
      out_q     <= out_d;
    end
  end

  assign carry_out = carry_q;
  assign norm      = norm_q;
  assign out       = out_q;
  assign hour      = {1'b0, hour_q};
  assign minute    = {1'b0, min_q};
  assign second    = {1'b0, sec_q};

endmodule

// File: doc/time_of_day.md
Name: time_of_day

Overview:
- Hour/minute/second counter that sits directly upstream of the date block.
- Its one-cycle midnight pulse drives the date block's carry_in.
- Uses the same six-button edit scheme and `mode` select as the date block, and exposes the same display/status style: 48-bit `out` and `norm`.
- Derives a 1 Hz tick from the system clock and supports interactive setting with commit/cancel.

Parameters:
- CLK_HZ, 50000000, system clock cycles per one-second tick; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- up  in  1  increment selected field; one-cycle pulse, debounced upstream.
- down  in  1  decrement selected field; one-cycle pulse.
- left  in  1  select the field to the left; one-cycle pulse.
- right  in  1  select the field to the right; one-cycle pulse.
- enter  in  1  enter edit (when mode=1) or commit edit; one-cycle pulse.
- esc  in  1  discard edit; one-cycle pulse.
- mode  in  1  1 = this block owns the buttons; 0 = all buttons ignored in RUN.
- carry_out  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover; feeds date carry_in.
- out  out  48  six ASCII digits HHMMSS; [47:40] is the hour tens digit.
- norm  out  1  1 in RUN, 0 in EDIT.
- hour  out  7  live hours, 0..23.
- minute  out  7  live minutes, 0..59.
- second  out  7  live seconds, 0..59.

Behaviour:
- Reset (async, rst=1):
  - hour/minute/second = 0, prescaler = 0.
  - state = RUN, norm = 1, carry_out = 0.
  - sel = HOUR, shadow fields = 0.
  - out = "000000" (0x303030303030).
- Prescaler:
  - Counts 0..CLK_HZ-1 every cycle, in both states.
  - tick = (count == CLK_HZ-1); count wraps to 0 on that same cycle.
  - First tick after reset occurs on the CLK_HZ-th rising edge.
- Live counter (advances on tick, in both RUN and EDIT):
  - second increments; 59 -> 0 carries into minute.
  - minute 59 -> 0 carries into hour.
  - hour 23 -> 0.
- carry_out:
  - Registered; goes to 1 for exactly one cycle, in the cycle after the edge where the count wraps 23:59:59 -> 00:00:00.
  - Never asserted by a commit or by reset.
- State machine, two states: RUN and EDIT.
  - RUN:
    - enter & mode -> EDIT.
    - On entry, shadow = live value as of that edge, sel = HOUR.
    - All other buttons ignored.
  - EDIT, mode is ignored. Only the highest-priority button asserted in a cycle acts; priority is esc > enter > up > down > left > right.
    - esc -> RUN; shadow discarded; live time unaffected.
    - enter (commit) -> RUN.
      - live = shadow; prescaler cleared to 0.
      - If a tick coincides with the commit, the commit wins: no increment that cycle and no carry_out.
    - up: selected shadow field +1, wrapping (hour 23->0, min/sec 59->0). No carry into the neighbouring field.
    - down: selected shadow field -1, wrapping (hour 0->23, min/sec 0->59). No borrow.
    - left: sel HOUR<-MIN<-SEC; saturates at HOUR.
    - right: sel HOUR->MIN->SEC; saturates at SEC.
- out (registered, one cycle latency from field change):
  - RUN: digits of the live time.
  - EDIT: digits of the shadow time, with no blinking.
  - Each digit = 8'h30 + BCD digit (tens = value/10, units = value%10, combinational conversion on 0..59).
- norm: registered, equals (state == RUN).
- Reset mid-edit: returns to RUN at 00:00:00 immediately; the shadow is lost.

Test Plan:
- Reset, CLK_HZ=4: rst pulse, then run 4*61 clk -> second=1 after the 4th edge; at 61 s: minute=1, second=1, out=0x303030313031 ("000101"), norm=1.
- Midnight carry, CLK_HZ=4: commit 23:59:58, run 8 clk -> after 2 ticks hour/min/sec = 0, out="000000", carry_out high for exactly 1 cycle; no carry_out anywhere else over 16 clk.
- Edit and commit: mode=1, enter -> norm=0; up x25 on HOUR -> shadow hour=1 (wrap through 23->0); right, down -> shadow min=59; right x3 -> sel stays SEC; enter -> hour=1, minute=59, norm=1, prescaler=0.
- Esc discard: live 10:20:30, mode=1, enter, up x3, esc -> norm=1, hour=10; out shows live digits; live seconds kept advancing during the edit.
- Mode gating and priority: mode=0, enter in RUN -> stays RUN. In EDIT, assert up & down same cycle -> only +1 applied. Assert esc & enter same cycle -> discard.
- Async reset mid-edit: in EDIT with shadow 05:06:07, raise rst between clock edges -> outputs immediately 0 and norm=1, before the next clk edge.
